// File: rtl/fpu_addsub_pipe.sv
// -----------------------------------------------------------------------------
// fpu_addsub_pipe
//   Pipelined IEEE-754 adder/subtractor, parametrised for single or double
//   precision. Subnormal inputs are flushed to zero and tiny results are
//   flushed to signed zero. Rounding is round-to-nearest, ties-to-even.
//
//   Pipeline (one register rank per stage, four ranks in total):
//     s1  unpack, apply op, swap, align smaller significand (G/R/S kept)
//     s2  significand add or subtract
//     s3  normalise (carry right-shift or leading-zero left-shift)
//     out round, renormalise, special/overflow/underflow selection, pack
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  operand handshake; in_ready = !out_valid || out_ready
//   a, b, op        operands; op=1 computes a-b
//   out_valid/ready result handshake; everything holds while out_ready=0
//   result          rounded sum
//   overflow        rounded result exceeded the largest finite value
//   underflow       nonzero result below min normal, flushed to zero
//   invalid         result is the canonical quiet NaN
// -----------------------------------------------------------------------------
module fpu_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int WIDTH = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             underflow,
  output logic             invalid
);

  localparam int ALN_W  = MAN_W + 3;            // hidden + fraction + G + R
  localparam int NORM_W = MAN_W + 4;            // hidden + fraction + G + R + S
  localparam int SUM_W  = MAN_W + 5;            // carry + NORM_W
  localparam int EW     = EXP_W + 2;            // signed working exponent
  localparam int LZ_W   = $clog2(NORM_W + 1);

  localparam logic [WIDTH-1:0]     QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [ALN_W-1:0]     ALN_ONES = '1;
  localparam logic signed [EW-1:0] EXP_INF  = {2'b00, {EXP_W{1'b1}}};

  // Leading-zero count; an all-zero vector yields NORM_W.
  function automatic logic [LZ_W-1:0] lzc(input logic [NORM_W-1:0] v);
    logic [LZ_W-1:0] n;
    n = LZ_W'(NORM_W);
    for (int i = 0; i < NORM_W; i++)
      if (v[i]) n = LZ_W'(NORM_W - 1 - i);
    return n;
  endfunction

  // Global advance enable: the whole pipe moves or the whole pipe holds.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------------------------------------------------------- stage 1
  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W:0]   man_a, man_b;
  logic             nan_a, nan_b, inf_a, inf_b, a_first;

  assign sign_a = a[WIDTH-1];
  assign sign_b = b[WIDTH-1] ^ op;
  assign exp_a  = a[WIDTH-2:MAN_W];
  assign exp_b  = b[WIDTH-2:MAN_W];
  // Exponent 0 means zero: subnormal fractions are discarded here.
  assign man_a  = (exp_a != '0) ? {1'b1, a[MAN_W-1:0]} : '0;
  assign man_b  = (exp_b != '0) ? {1'b1, b[MAN_W-1:0]} : '0;
  assign nan_a  = (exp_a == '1) && (a[MAN_W-1:0] != '0);
  assign nan_b  = (exp_b == '1) && (b[MAN_W-1:0] != '0);
  assign inf_a  = (exp_a == '1) && (a[MAN_W-1:0] == '0);
  assign inf_b  = (exp_b == '1) && (b[MAN_W-1:0] == '0);
  assign a_first = {exp_a, man_a} >= {exp_b, man_b};

  logic              big_sign, small_sign;
  logic [EXP_W-1:0]  big_exp, small_exp, shift;
  logic [MAN_W:0]    big_man, small_man;
  logic [ALN_W-1:0]  small_ext;
  logic [NORM_W-1:0] small_aligned;

  // NOTE: every variable gets a default at the top of an always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin : align
    big_sign   = sign_a;
    big_exp    = exp_a;
    big_man    = man_a;
    small_sign = sign_b;
    small_exp  = exp_b;
    small_man  = man_b;
    if (!a_first) begin
      big_sign   = sign_b;
      big_exp    = exp_b;
      big_man    = man_b;
      small_sign = sign_a;
      small_exp  = exp_a;
      small_man  = man_a;
    end
    shift     = big_exp - small_exp;
    small_ext = {small_man, 2'b00};
    // Bits shifted past R collapse into sticky; a shift of ALN_W or more
    // moves everything out and only sticky survives.
    small_aligned = {small_ext >> shift, |(small_ext & ~(ALN_ONES << shift))};
  end

  logic             spec;
  logic             spec_inv;
  logic [WIDTH-1:0] spec_res;

  always_comb begin : classify
    spec     = 1'b0;
    spec_inv = 1'b0;
    spec_res = '0;
    if (nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b))) begin
      spec     = 1'b1;
      spec_inv = 1'b1;
      spec_res = QNAN;
    end else if (inf_a) begin
      spec     = 1'b1;
      spec_res = {sign_a, a[WIDTH-2:0]};
    end else if (inf_b) begin
      spec     = 1'b1;
      spec_res = {sign_b, b[WIDTH-2:0]};
    end
  end

  logic              s1_valid, s1_sign, s1_sub, s1_spec, s1_inv;
  logic [EXP_W-1:0]  s1_exp;
  logic [MAN_W:0]    s1_man;
  logic [NORM_W-1:0] s1_aligned;
  logic [WIDTH-1:0]  s1_spec_res;

  // ---------------------------------------------------------------- stage 2
  logic [SUM_W-1:0] add_big, add_small, sum;

  assign add_big   = {1'b0, s1_man, 3'b000};
  assign add_small = {1'b0, s1_aligned};
  // The larger magnitude is always on the left, so subtraction never borrows.
  assign sum       = s1_sub ? add_big - add_small : add_big + add_small;

  logic             s2_valid, s2_sign, s2_spec, s2_inv;
  logic [EXP_W-1:0] s2_exp;
  logic [SUM_W-1:0] s2_sum;
  logic [WIDTH-1:0] s2_spec_res;

  // ---------------------------------------------------------------- stage 3
  logic [LZ_W-1:0]       lz;
  logic signed [EW-1:0]  exp_ext, norm_exp;
  logic [NORM_W-1:0]     norm;

  assign lz      = lzc(s2_sum[NORM_W-1:0]);
  assign exp_ext = {2'b00, s2_exp};

  always_comb begin : normalise
    if (s2_sum[SUM_W-1]) begin
      // Carry out: drop one bit into sticky and bump the exponent.
      norm     = {s2_sum[SUM_W-1:2], |s2_sum[1:0]};
      norm_exp = exp_ext + EW'(1);
    end else begin
      norm     = s2_sum[NORM_W-1:0] << lz;
      norm_exp = exp_ext - EW'(lz);
    end
  end

  logic              s3_valid, s3_sign, s3_zero, s3_spec, s3_inv;
  logic signed [EW-1:0] s3_exp;
  logic [NORM_W-1:0] s3_norm;
  logic [WIDTH-1:0]  s3_spec_res;

  // ------------------------------------------------------- round and pack
  logic                 rnd_up;
  logic [MAN_W+1:0]     rounded;
  logic signed [EW-1:0] r_exp;
  logic [MAN_W-1:0]     r_frac;
  logic [WIDTH-1:0]     pack_res;
  logic                 pack_ovf, pack_unf, pack_inv;

  // Ties go to even: round up on G only when R|S or the kept LSB is set.
  assign rnd_up  = s3_norm[2] & (s3_norm[3] | s3_norm[1] | s3_norm[0]);
  assign rounded = {1'b0, s3_norm[NORM_W-1:3]} + (MAN_W+2)'(rnd_up);
  assign r_exp   = s3_exp + EW'(rounded[MAN_W+1]);
  assign r_frac  = rounded[MAN_W+1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];

  always_comb begin : pack
    pack_res = {s3_sign, r_exp[EXP_W-1:0], r_frac};
    pack_ovf = 1'b0;
    pack_unf = 1'b0;
    pack_inv = 1'b0;
    if (s3_spec) begin
      pack_res = s3_spec_res;
      pack_inv = s3_inv;
    end else if (s3_zero) begin
      pack_res = '0;                      // exact cancellation is +0
    end else if (r_exp[EW-1] || (r_exp == '0)) begin
      pack_res = {s3_sign, {(WIDTH-1){1'b0}}};
      pack_unf = 1'b1;
    end else if (r_exp >= EXP_INF) begin
      pack_res = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      pack_ovf = 1'b1;
    end
  end

  // ---------------------------------------------------------------- registers
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin : ctrl_regs
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      invalid   <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      s3_valid  <= s2_valid;
      out_valid <= s3_valid;
      result    <= s3_valid ? pack_res : '0;
      overflow  <= s3_valid && pack_ovf;
      underflow <= s3_valid && pack_unf;
      invalid   <= s3_valid && pack_inv;
    end
  end

  // NOTE: datapath stage registers carry no reset; their contents are only
  // observed behind a valid bit, which is reset.
  always_ff @(posedge clk) begin : data_regs
    if (en) begin
      s1_sign     <= big_sign;
      s1_sub      <= big_sign ^ small_sign;
      s1_exp      <= big_exp;
      s1_man      <= big_man;
      s1_aligned  <= small_aligned;
      s1_spec     <= spec;
      s1_inv      <= spec_inv;
      s1_spec_res <= spec_res;

      s2_sign     <= s1_sign;
      s2_exp      <= s1_exp;
      s2_sum      <= sum;
      s2_spec     <= s1_spec;
      s2_inv      <= s1_inv;
      s2_spec_res <= s1_spec_res;

      s3_sign     <= s2_sign;
      s3_exp      <= norm_exp;
      s3_norm     <= norm;
      s3_zero     <= (s2_sum == '0);
      s3_spec     <= s2_spec;
      s3_inv      <= s2_inv;
      s3_spec_res <= s2_spec_res;
    end
  end

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_fpu_addsub_pipe
//   Single-precision instance checked against a reference model built on the
//   simulator's double arithmetic (exact enough that a second rounding to 24
//   bits is still correctly rounded), a double-precision instance checked with
//   directed vectors and native real arithmetic, plus latency, backpressure
//   and mid-flight reset scenarios.
// -----------------------------------------------------------------------------
module tb_fpu_addsub_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, op, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic        overflow, underflow, invalid;

  logic        in_valid_d, in_ready_d, op_d, out_valid_d, out_ready_d;
  logic [63:0] a_d, b_d, result_d;
  logic        overflow_d, underflow_d, invalid_d;

  fpu_addsub_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .underflow(underflow), .invalid(invalid)
  );

  fpu_addsub_pipe #(.EXP_W(11), .MAN_W(52)) dut_d (
    .clk(clk), .rst(rst), .in_valid(in_valid_d), .in_ready(in_ready_d),
    .a(a_d), .b(b_d), .op(op_d), .out_valid(out_valid_d), .out_ready(out_ready_d),
    .result(result_d), .overflow(overflow_d), .underflow(underflow_d), .invalid(invalid_d)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // ---------------------------------------------------------- reference model
  function automatic real sp_to_real(input logic s, input logic [7:0] e, input logic [22:0] f);
    if (e == 8'h00) return 0.0;
    return $bitstoreal({s, 11'(int'(e) + 896), f, 29'd0});
  endfunction

  // Returns {invalid, overflow, underflow, result}.
  function automatic logic [34:0] sp_model(input logic [31:0] x, input logic [31:0] y, input logic o);
    logic        sx, sy, s, g, st;
    logic [7:0]  ex, ey;
    logic [22:0] fx, fy;
    logic [63:0] d;
    logic [24:0] keep;
    real         r;
    int          se;
    sx = x[31]; ex = x[30:23]; fx = x[22:0];
    sy = y[31] ^ o; ey = y[30:23]; fy = y[22:0];
    if ((ex == 8'hff && fx != 0) || (ey == 8'hff && fy != 0) ||
        (ex == 8'hff && ey == 8'hff && sx != sy))
      return {3'b100, 32'h7fc00000};
    if (ex == 8'hff) return {3'b000, sx, 8'hff, 23'd0};
    if (ey == 8'hff) return {3'b000, sy, 8'hff, 23'd0};
    r = sp_to_real(sx, ex, fx) + sp_to_real(sy, ey, fy);
    if (r == 0.0) return 35'd0;
    d    = $realtobits(r);
    s    = d[63];
    keep = {2'b01, d[51:29]};
    g    = d[28];
    st   = |d[27:0];
    if (g && (st || keep[0])) keep = keep + 25'd1;
    se = int'(d[62:52]) - 1023 + 127;
    if (keep[24]) se = se + 1;
    if (se >= 255) return {3'b010, s, 8'hff, 23'd0};
    if (se <= 0)   return {3'b001, s, 31'd0};
    return {3'b000, s, 8'(se), keep[22:0]};
  endfunction

  function automatic logic [31:0] rand_sp();
    logic [7:0]  e;
    logic [22:0] f;
    f = 23'($urandom);
    case ($urandom_range(0, 15))
      0:       e = 8'hff;
      1:       e = 8'h00;
      2:       e = 8'($urandom_range(1, 3));
      3:       e = 8'($urandom_range(250, 254));
      4, 5:    e = 8'($urandom_range(1, 254));
      default: e = 8'($urandom_range(120, 135));
    endcase
    if (e == 8'hff && $urandom_range(0, 1) == 0) f = '0;
    return {1'($urandom), e, f};
  endfunction

  task automatic next_ops();
    a  = rand_sp();
    b  = ($urandom_range(0, 3) == 0) ? {a[31:8], 8'($urandom)} : rand_sp();
    op = 1'($urandom);
  endtask

  // ------------------------------------------- single-precision scoreboard
  logic [34:0] exp_q[$];
  logic        hold_v = 1'b0;
  logic [34:0] held;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (hold_v)
        check("stall_hold", {28'd0, out_valid, invalid, overflow, underflow, result}, {28'd0, 1'b1, held});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 64'(out_valid), 64'(0));
        else check("sp_result", {29'd0, invalid, overflow, underflow, result}, {29'd0, exp_q.pop_front()});
      end
      hold_v = out_valid && !out_ready;
      held   = {invalid, overflow, underflow, result};
      if (in_valid && in_ready) exp_q.push_back(sp_model(a, b, op));
    end
  end

  // ------------------------------------------------------- directed runners
  // Called just after a rising edge with an empty pipe.
  task automatic sp_run(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic o, input logic [31:0] r, input logic [2:0] fl);
    int lat;
    out_ready = 1'b1;
    a = x; b = y; op = o; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(3));
    check({tag, "_res"}, {29'd0, invalid, overflow, underflow, result}, {29'd0, fl, r});
    @(posedge clk); #1;
  endtask

  task automatic dp_run(input string tag, input logic [63:0] x, input logic [63:0] y,
                        input logic o, input logic [63:0] r, input logic [2:0] fl);
    int lat;
    out_ready_d = 1'b1;
    a_d = x; b_d = y; op_d = o; in_valid_d = 1'b1;
    @(posedge clk); #1;
    in_valid_d = 1'b0;
    lat = 0;
    while (!out_valid_d && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(3));
    check({tag, "_res"}, result_d, r);
    check({tag, "_flags"}, {61'd0, invalid_d, overflow_d, underflow_d}, {61'd0, fl});
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] x, y;
    logic        o, acc;
    real         rx, ry;
    int          sent, cyc;

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b1;
    in_valid_d = 1'b0; a_d = '0; b_d = '0; op_d = 1'b0; out_ready_d = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_outputs", {29'd0, invalid, overflow, underflow, result}, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_dp_outputs", {60'd0, out_valid_d, invalid_d, overflow_d, underflow_d} | result_d, 64'd0);

    // Single-precision directed vectors.
    sp_run("tie_even",   32'h40866666, 32'h404CCCCD, 1'b0, 32'h40ECCCCC, 3'b000);
    sp_run("sub_half",   32'h3F800000, 32'h3F000000, 1'b1, 32'h3F000000, 3'b000);
    sp_run("cancel",     32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 3'b000);
    sp_run("inf_m_inf",  32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100);
    sp_run("overflow",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010);
    sp_run("underflow",  32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 3'b001);
    sp_run("inf_finite", 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000);
    sp_run("nan_in",     32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
    sp_run("tie_down",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000);
    sp_run("above_tie",  32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 3'b000);
    sp_run("one_m_ulp",  32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 3'b000);

    // Double precision.
    dp_run("dp_two",  64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0, 64'h4000000000000000, 3'b000);
    dp_run("dp_ovf",  64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 1'b0, 64'h7FF0000000000000, 3'b010);
    dp_run("dp_sub",  64'h3FF8000000000000, 64'h3FE0000000000000, 1'b1, 64'h3FF0000000000000, 3'b000);
    for (int i = 0; i < 24; i++) begin
      x = {1'($urandom), 11'($urandom_range(1000, 1050)), 52'({$urandom, $urandom})};
      y = {1'($urandom), 11'($urandom_range(1000, 1050)), 52'({$urandom, $urandom})};
      if (i % 4 == 0) y = {~x[63], x[62:0]};
      o  = 1'($urandom);
      rx = $bitstoreal(x);
      ry = $bitstoreal(y);
      dp_run("dp_rand", x, y, o, $realtobits(o ? rx - ry : rx + ry), 3'b000);
    end

    // Random stream with backpressure; the scoreboard checks every result.
    sent = 0; cyc = 0;
    next_ops();
    in_valid = 1'b1;
    out_ready = 1'($urandom);
    while (sent < 300 && cyc < 20000) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        next_ops();
      end
      in_valid  = (sent < 10) ? 1'b1 : ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom);
    end
    check("bp_sent", 64'(sent), 64'(300));
    in_valid = 1'b0; out_ready = 1'b1; cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("bp_drain", 64'(exp_q.size()), 64'(0));

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      next_ops();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_outputs", {29'd0, invalid, overflow, underflow, result}, 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("mid_rst_idle", 64'(out_valid), 64'(0));
    end
    sp_run("after_rst", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_addsub_pipe.md
# fpu_addsub_pipe

Parametrised, pipelined IEEE-754 floating-point adder/subtractor. It is the successor to the single-precision combinational adder: one RTL source serves both single and double precision, and it adds a subtract mode, round-to-nearest-even, special-value handling and a valid/ready handshake with backpressure. It sits in the ALU datapath between the operand-issue logic and the result writeback.

## Interface
- `EXP_W`, default 8: exponent field width. Use 11 for double precision.
- `MAN_W`, default 23: fraction field width. Use 52 for double precision.
- `WIDTH`, default `1+EXP_W+MAN_W`: operand and result width. Derived; do not override.
- `clk`, in, 1: the single clock. All state is clocked on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `in_valid`, in, 1: an operand pair is presented.
- `in_ready`, out, 1: the block accepts the pair this cycle.
- `a`, in, WIDTH: operand A.
- `b`, in, WIDTH: operand B.
- `op`, in, 1: 0 computes A+B, 1 computes A−B (the sign of B is inverted).
- `out_valid`, out, 1: the result and flags are valid.
- `out_ready`, in, 1: downstream consumes the result this cycle.
- `result`, out, WIDTH: the rounded sum.
- `overflow`, out, 1: the rounded result exceeded the largest finite value.
- `underflow`, out, 1: a nonzero exact result fell below the minimum normal and was flushed to zero.
- `invalid`, out, 1: the result is NaN (a NaN input, or inf−inf).

## Operation
- **Stage 1 (unpack/align):**
  - Apply `op` to the sign of B.
  - Treat exponent 0 as zero; subnormal inputs are flushed.
  - Swap the operands so the larger magnitude comes first.
  - Right-shift the smaller significand by the exponent difference, keeping guard, round and sticky bits. A shift of MAN_W+3 or more leaves sticky only.
  - Classify special cases (NaN, inf).
- **Stage 2 (add):**
  - Add the significands when the signs match; otherwise subtract the smaller from the larger.
  - Use a MAN_W+5-bit adder to hold the carry and the G/R/S bits.
- **Stage 3 (normalise/round/pack):**
  - On carry-out, shift right by 1 and increment the exponent.
  - Otherwise, left-shift by the leading-zero count and decrement the exponent.
  - Round to nearest, ties to even. If rounding carries out, renormalise.
- **Result rules:**
  - Exact cancellation gives +0 with all flags 0.
  - A biased exponent of 2^EXP_W−1 or more gives signed infinity with `overflow`=1.
  - A biased exponent of 0 or less with a nonzero exact result gives signed zero with `underflow`=1.
  - Any NaN input, or inf + (−inf) after `op` is applied, gives canonical qNaN (sign 0, exponent all ones, fraction MSB 1, rest 0) with `invalid`=1.
  - inf combined with a finite operand gives that inf with no flags set.
- Flags travel with their result and are valid only while `out_valid`=1.

## Timing
- **Latency:** exactly 3 cycles from acceptance (`in_valid`&&`in_ready` at edge N) to `out_valid`=1 after edge N+3, provided no stall occurs.
- **Throughput:** one operation per cycle.
- **Stall:** `en = !out_valid || out_ready` is a global advance enable, and `in_ready` = `en` (a combinational path from `out_ready`).
  - While `en`=0, all stage registers, including `result` and the flags, hold.
- The output stays stable while `out_valid`=1 and `out_ready`=0.
- Bubbles (`in_valid`=0 while `en`=1) propagate as invalid stage entries.
- **Reset:**
  - Clears all stage valid bits, `out_valid`, `result`, `overflow`, `underflow` and `invalid` to 0. `in_ready` is 1 after reset.
  - Reset mid-operation discards every in-flight operation. No result for them is ever presented.
- Simultaneous output consume and input accept in the same cycle is legal and loses nothing.

## Test plan
- **Tie-to-even (defaults):** `a`=0x40866666 (4.2), `b`=0x404CCCCD (3.2), `op`=0 → `result`=0x40ECCCCC, all flags 0, `out_valid` exactly 3 cycles after acceptance.
- **Subtract, cancellation, special values:**
  - `op`=1 on 0x3F800000 and 0x3F000000 → 0x3F000000.
  - `op`=0 on 0x3F800000 and 0xBF800000 → 0x00000000, flags 0.
  - 0x7F800000 + 0xFF800000 → 0x7FC00000, `invalid`=1.
- **Overflow and underflow:**
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, `overflow`=1.
  - 0x00C00000 − 0x00800000 (`op`=1) → 0x00000000, `underflow`=1.
- **Double precision (`EXP_W`=11, `MAN_W`=52):**
  - 0x3FF0000000000000 + 0x3FF0000000000000 → 0x4000000000000000.
  - 0x7FEFFFFFFFFFFFFF doubled → 0x7FF0000000000000 with `overflow`=1.
- **Backpressure:**
  - Stream 10 back-to-back operations while `out_ready` toggles randomly.
  - Every result must appear in order, exactly once, matching the reference model.
  - `result` must stay stable while `out_ready`=0, and `in_ready` must track `!out_valid||out_ready`.
- **Reset mid-flight:**
  - Accept 3 operations, then assert `rst` for 1 cycle.
  - Next cycle: `out_valid`=0 and all outputs 0. No stale result appears during the following 5 idle cycles.
  - A new operation then completes with 3-cycle latency.
